// File: rtl/sram_avm_if.sv
// Avalon-MM initiator bundle for the HPS-exposed on-chip SRAM window.
interface sram_avm_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W+1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic [3:0]        avm_byteenable;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;
  logic              avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  avm_readdata, avm_readdatavalid, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    output avm_readdata, avm_readdatavalid, avm_waitrequest
  );
endinterface

// File: rtl/sram_pattern_master.sv
// Fills an SRAM word range with seed+i or reads it back with pipelined reads and counts mismatches.
// Define SRAM_CHECKSUM_EN to add a running checksum output over written / returned words.
module sram_pattern_master #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_PENDING = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic [15:0]       error_count,
  output logic [ADDR_W-1:0] first_err_addr,
`ifdef SRAM_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  sram_avm_if.master        avm
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {IDLE, FILL, RD_ISSUE, RD_DRAIN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] word_addr;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  issued;
  logic [CNT_W-1:0]  received;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] wdata_q;
  logic              read_q;
  logic              write_q;

  logic              wr_acc;
  logic              rd_acc;
  logic              rd_in;
  logic              mismatch;
  logic              rd_more;
  logic [CNT_W-1:0]  issued_n;
  logic [CNT_W-1:0]  received_n;
  logic [CNT_W-1:0]  pending_n;
  logic [ADDR_W-1:0] next_addr;
  logic [DATA_W-1:0] next_data;
  logic [DATA_W-1:0] exp_word;

  assign avm.avm_address    = {word_addr, 2'b00};
  assign avm.avm_read       = read_q;
  assign avm.avm_write      = write_q;
  assign avm.avm_writedata  = wdata_q;
  assign avm.avm_byteenable = 4'hF;

  // Post-edge counter values; pending counts a same-cycle issue and return as net zero.
  always_comb begin
    wr_acc     = write_q && !avm.avm_waitrequest;
    rd_acc     = read_q && !avm.avm_waitrequest;
    rd_in      = avm.avm_readdatavalid && (state == RD_ISSUE || state == RD_DRAIN);
    issued_n   = issued + CNT_W'(wr_acc || rd_acc);
    received_n = received + CNT_W'(rd_in);
    pending_n  = issued_n - received_n;
    rd_more    = (issued_n < len_q) && (pending_n < CNT_W'(MAX_PENDING));
    next_addr  = base_q + ADDR_W'(issued_n);
    next_data  = seed_q + DATA_W'(issued_n);
    exp_word   = seed_q + DATA_W'(received);
    mismatch   = rd_in && (avm.avm_readdata != exp_word);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      error_count    <= '0;
      first_err_addr <= '0;
      base_q         <= '0;
      word_addr      <= '0;
      len_q          <= '0;
      issued         <= '0;
      received       <= '0;
      seed_q         <= '0;
      wdata_q        <= '0;
      read_q         <= 1'b0;
      write_q        <= 1'b0;
`ifdef SRAM_CHECKSUM_EN
      checksum       <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q         <= base_addr;
            len_q          <= length;
            seed_q         <= seed;
            word_addr      <= base_addr;
            wdata_q        <= seed;
            error_count    <= '0;
            first_err_addr <= '0;
            issued         <= '0;
            received       <= '0;
            busy           <= 1'b1;
`ifdef SRAM_CHECKSUM_EN
            checksum       <= '0;
`endif
            if (length == '0) begin
              state <= DONE;
            end else if (!mode) begin
              state   <= FILL;
              write_q <= 1'b1;
            end else begin
              state  <= RD_ISSUE;
              read_q <= 1'b1;
            end
          end
        end
        FILL: begin
          if (wr_acc) begin
            issued <= issued_n;
`ifdef SRAM_CHECKSUM_EN
            checksum <= checksum + wdata_q;
`endif
            if (issued_n == len_q) begin
              write_q <= 1'b0;
              state   <= DONE;
            end else begin
              word_addr <= next_addr;
              wdata_q   <= next_data;
            end
          end
        end
        RD_ISSUE: begin
          issued <= issued_n;
          // Address only moves once the current request is taken or none is pending.
          if (!read_q || rd_acc) begin
            read_q    <= rd_more;
            word_addr <= next_addr;
          end
          if (issued_n == len_q) state <= RD_DRAIN;
        end
        RD_DRAIN: begin
          if (received_n == len_q) state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (rd_in) begin
        received <= received_n;
`ifdef SRAM_CHECKSUM_EN
        checksum <= checksum + avm.avm_readdata;
`endif
        if (mismatch) begin
          if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
          if (error_count == 16'd0) first_err_addr <= base_q + ADDR_W'(received);
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_pattern_master.sv
// Directed bench for sram_pattern_master with a behavioural Avalon SRAM slave and bus monitor.
module tb_sram_pattern_master;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic [DATA_W-1:0] seed;
  logic              busy;
  logic              done;
  logic [15:0]       error_count;
  logic [ADDR_W-1:0] first_err_addr;
`ifdef SRAM_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  sram_avm_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) avm ();

  sram_pattern_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .mode           (mode),
    .base_addr      (base_addr),
    .length         (length),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .error_count    (error_count),
    .first_err_addr (first_err_addr),
`ifdef SRAM_CHECKSUM_EN
    .checksum       (checksum),
`endif
    .avm            (avm)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave and monitor state
  logic [31:0] mem [0:65535];
  int          lat = 1;
  bit          wait_rand = 1'b0;
  int          corrupt_word = -1;
  bit          corrupt_all = 1'b0;
  int          cyc = 0;
  int          rsp_addr_q[$];
  int          rsp_due_q[$];
  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          rd_addr_q[$];
  int          wr_cnt, rd_cnt, rdv_cnt, done_cnt, viol, pend, max_pend;
  int          start_cyc, done_cyc, first_wr_cyc, last_wr_cyc, rdv_at_done;
  int          a;
  bit          stalled = 1'b0;
  logic [17:0] p_addr;
  logic        p_rd, p_wr;
  logic [31:0] p_wd;

  // Mid-cycle slave: drives inputs for the next rising edge and logs accepted transfers.
  always @(negedge clk) begin
    cyc++;
    if (stalled && (avm.avm_address !== p_addr || avm.avm_read !== p_rd ||
                    avm.avm_write !== p_wr || avm.avm_writedata !== p_wd)) viol++;
    if (avm.avm_read && avm.avm_write) viol++;
    if (rsp_due_q.size() > 0 && rsp_due_q[0] <= cyc) begin
      a = rsp_addr_q.pop_front();
      void'(rsp_due_q.pop_front());
      avm.avm_readdatavalid = 1'b1;
      avm.avm_readdata = corrupt_all ? ~mem[a] : ((a == corrupt_word) ? 32'h0000DEAD : mem[a]);
      rdv_cnt++;
      pend--;
    end else begin
      avm.avm_readdatavalid = 1'b0;
      avm.avm_readdata = '0;
    end
    avm.avm_waitrequest = wait_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    if (!reset && avm.avm_read && !avm.avm_waitrequest) begin
      rsp_addr_q.push_back(int'(avm.avm_address[17:2]));
      rsp_due_q.push_back(cyc + lat);
      rd_addr_q.push_back(int'(avm.avm_address[17:2]));
      rd_cnt++;
      pend++;
    end
    if (!reset && avm.avm_write && !avm.avm_waitrequest) begin
      mem[int'(avm.avm_address[17:2])] = avm.avm_writedata;
      wr_addr_q.push_back(int'(avm.avm_address));
      wr_data_q.push_back(avm.avm_writedata);
      if (wr_cnt == 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      wr_cnt++;
    end
    if (pend > max_pend) max_pend = pend;
    stalled = !reset && (avm.avm_read || avm.avm_write) && avm.avm_waitrequest;
    p_addr = avm.avm_address;
    p_rd   = avm.avm_read;
    p_wr   = avm.avm_write;
    p_wd   = avm.avm_writedata;
    if (start && start_cyc < 0) start_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      rdv_at_done = rdv_cnt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_cnt = 0; rd_cnt = 0; rdv_cnt = 0; done_cnt = 0; viol = 0; max_pend = pend;
    start_cyc = -1; done_cyc = -1; first_wr_cyc = -1; last_wr_cyc = -1; rdv_at_done = -1;
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
  endtask

  task automatic run(input bit m, input int b, input int len, input logic [31:0] s);
    clear_mon();
    mode = m; base_addr = 16'(b); length = 17'(len); seed = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 2000) begin
      tick();
      n++;
    end
    tick();
    tick();
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    pend = 0;
    clear_mon();
    reset = 1'b1; start = 1'b0; mode = 1'b0; base_addr = '0; length = '0; seed = '0;
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(error_count), 64'd0);
    check("rst_first_err", 64'(first_err_addr), 64'd0);
    check("rst_addr", 64'(avm.avm_address), 64'd0);
    check("rst_rd_wr", 64'({avm.avm_read, avm.avm_write}), 64'd0);
    check("rst_wdata", 64'(avm.avm_writedata), 64'd0);
    check("rst_be", 64'(avm.avm_byteenable), 64'hF);
    reset = 1'b0;
    tick();

    // Fill 8 words, no stalls: one write per cycle
    run(1'b0, 'h10, 8, 32'h1000);
    check("fill_busy", 64'(busy), 64'd1);
    wait_done("fill");
    check("fill_wr_cnt", 64'(wr_cnt), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fill_addr%0d", i), 64'(wr_addr_q[i]), 64'('h40 + 4 * i));
      check($sformatf("fill_data%0d", i), 64'(wr_data_q[i]), 64'(32'h1000 + i));
    end
    check("fill_back2back", 64'(last_wr_cyc - first_wr_cyc), 64'd7);
    check("fill_done_lat", 64'(done_cyc - start_cyc), 64'd10);
    check("fill_no_reads", 64'(rd_cnt), 64'd0);
`ifdef SRAM_CHECKSUM_EN
    check("fill_checksum", 64'(checksum), 64'h801C);
`endif

    // Verify the same range
    run(1'b1, 'h10, 8, 32'h1000);
    wait_done("verify");
    check("verify_err", 64'(error_count), 64'd0);
    check("verify_first_err", 64'(first_err_addr), 64'd0);
    check("verify_rd_cnt", 64'(rd_cnt), 64'd8);
    check("verify_rdv_at_done", 64'(rdv_at_done), 64'd8);
    check("verify_no_writes", 64'(wr_cnt), 64'd0);
`ifdef SRAM_CHECKSUM_EN
    check("verify_checksum", 64'(checksum), 64'h801C);
`endif

    // One corrupted word at offset 3
    corrupt_word = 'h13;
    run(1'b1, 'h10, 8, 32'h1000);
    wait_done("corrupt");
    check("corrupt_err", 64'(error_count), 64'd1);
    check("corrupt_first_err", 64'(first_err_addr), 64'h13);
    corrupt_word = -1;

    // Random stalls and read latency 3
    wait_rand = 1'b1;
    run(1'b0, 'h100, 16, 32'hA5A50000);
    wait_done("bp_fill");
    check("bp_fill_viol", 64'(viol), 64'd0);
    check("bp_fill_wr_cnt", 64'(wr_cnt), 64'd16);
    lat = 3;
    run(1'b1, 'h100, 16, 32'hA5A50000);
    wait_done("bp_verify");
    check("bp_viol", 64'(viol), 64'd0);
    check("bp_max_pend_le4", 64'(max_pend <= 4), 64'd1);
    check("bp_rd_cnt", 64'(rd_cnt), 64'd16);
    check("bp_rdv_at_done", 64'(rdv_at_done), 64'd16);
    check("bp_err", 64'(error_count), 64'd0);
    wait_rand = 1'b0;
    lat = 1;

    // Address wrap at the top of the window
    run(1'b0, 'hFFFE, 4, 32'h77);
    wait_done("wrap_fill");
    check("wrap_addr0", 64'(wr_addr_q[0]), 64'h3FFF8);
    check("wrap_addr1", 64'(wr_addr_q[1]), 64'h3FFFC);
    check("wrap_addr2", 64'(wr_addr_q[2]), 64'h0);
    check("wrap_addr3", 64'(wr_addr_q[3]), 64'h4);
    run(1'b1, 'hFFFE, 4, 32'h77);
    wait_done("wrap_verify");
    check("wrap_rd_addr2", 64'(rd_addr_q[2]), 64'h0);
    check("wrap_err", 64'(error_count), 64'd0);

    // Zero length: done two cycles after start, no traffic
    run(1'b1, 'h20, 0, 32'h0);
    wait_done("len0");
    check("len0_done_lat", 64'(done_cyc - start_cyc), 64'd2);
    check("len0_traffic", 64'(rd_cnt + wr_cnt), 64'd0);

    // Start while busy is ignored
    run(1'b0, 'h200, 8, 32'h50);
    tick();
    tick();
    mode = 1'b1; base_addr = 16'h300; length = 17'd2; seed = 32'h0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("busy_start");
    check("busy_start_wr_cnt", 64'(wr_cnt), 64'd8);
    check("busy_start_rd_cnt", 64'(rd_cnt), 64'd0);
    check("busy_start_last_addr", 64'(wr_addr_q[7]), 64'h81C);
    check("busy_start_done_lat", 64'(done_cyc - start_cyc), 64'd10);

    // Reset with three reads outstanding; late responses are bad data
    lat = 3;
    run(1'b1, 'h10, 8, 32'h1000);
    n = 0;
    while (rd_cnt < 5 && n < 100) begin
      tick();
      n++;
    end
    check("rst_mid_reached5", 64'(rd_cnt), 64'd5);
    reset = 1'b1;
    corrupt_all = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_read", 64'(avm.avm_read), 64'd0);
    repeat (8) tick();
    check("rst_mid_no_done", 64'(done_cnt), 64'd0);
    check("rst_mid_err", 64'(error_count), 64'd0);
    check("rst_mid_idle_busy", 64'(busy), 64'd0);
    corrupt_all = 1'b0;
    lat = 1;
    pend = 0;

`ifdef SRAM_CHECKSUM_EN
    run(1'b0, 'h400, 3, 32'hFFFFFFFE);
    wait_done("cks");
    check("cks_wrap_sum", 64'(checksum), 64'hFFFFFFFD);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
